// File: rtl/rob_nport.sv
// rtl/rob_nport.sv - N-write-port reorder buffer returning read data in TID allocation order
// Allocation order is tracked by wrap-bit pointers; per-entry alloc/done bits gate in-order release.
module rob_nport #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int TID_WIDTH  = 6,
  parameter int NUM_WR     = 2,
  parameter int AFULL_THR  = 62
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_req_i,
  input  logic [ID_WIDTH-1:0]            alloc_id_i,
  output logic                           alloc_gnt_o,
  output logic [TID_WIDTH-1:0]           alloc_tid_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR*TID_WIDTH-1:0]    wr_tid_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
  output logic                           afull_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [ID_WIDTH-1:0]            rid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [TID_WIDTH:0]             count_o,
  output logic                           err_o
);

  localparam int PW    = TID_WIDTH + 1;
  localparam int DEPTH = 1 << TID_WIDTH;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THR);

  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [DEPTH-1:0]      r_alloc;
  logic [DEPTH-1:0]      r_done;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_id   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  logic [PW-1:0]         w_count;
  logic [TID_WIDTH-1:0]  w_head_idx;
  logic [TID_WIDTH-1:0]  w_tail_idx;
  logic                  w_gnt;
  logic                  w_rvalid;
  logic                  w_rel;
  logic [TID_WIDTH-1:0]  w_wr_tid  [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_WR];
  logic [NUM_WR-1:0]     w_wr_ok;
  logic                  w_wr_err;
  logic                  w_clash;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_unpack
    assign w_wr_tid[g]  = wr_tid_i[g*TID_WIDTH +: TID_WIDTH];
    assign w_wr_data[g] = wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[TID_WIDTH-1:0];
  assign w_tail_idx = r_tail[TID_WIDTH-1:0];
  // A release in the same cycle never frees a slot for a full-buffer request.
  assign w_gnt      = alloc_req_i & (w_count != DEPTH_V);
  assign w_rvalid   = r_alloc[w_head_idx] & r_done[w_head_idx];
  assign w_rel      = w_rvalid & rready_i;

  assign alloc_gnt_o = w_gnt;
  assign alloc_tid_o = w_tail_idx;
  assign count_o     = w_count;
  assign afull_o     = (w_count >= AFULL_V);
  assign rvalid_o    = w_rvalid;
  assign rid_o       = w_rvalid ? r_id[w_head_idx] : '0;
  assign rdata_o     = w_rvalid ? r_data[w_head_idx] : '0;
  assign err_o       = r_err;

  // Lower port wins a same-TID clash; any dropped write flags an error.
  always_comb begin
    w_wr_ok  = '0;
    w_wr_err = 1'b0;
    w_clash  = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_clash = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (wr_en_i[j] && (w_wr_tid[j] == w_wr_tid[k])) begin
          w_clash = 1'b1;
        end
      end
      if (wr_en_i[k]) begin
        if (w_clash || !r_alloc[w_wr_tid[k]] || r_done[w_wr_tid[k]]) begin
          w_wr_err = 1'b1;
        end else begin
          w_wr_ok[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_alloc <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_alloc[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_ONE;
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_wr_ok[k]) begin
          r_done[w_wr_tid[k]] <= 1'b1;
        end
      end
      if (w_rel) begin
        r_alloc[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + PTR_ONE;
      end
      if (w_wr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Payload storage is left unreset; alloc/done bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_id[w_tail_idx] <= alloc_id_i;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (w_wr_ok[k]) begin
        r_data[w_wr_tid[k]] <= w_wr_data[k];
      end
    end
  end

endmodule
